id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
Pipeline register between decode (operand read from the register file) and execute. Captures decoded operands and control each cycle. Detects load-use hazards against the instruction currently in EX and inserts a bubble. Honours branch flush and global memory hold, and keeps a saturating count of inserted load-use bubbles for performance debug.

Parameters:
CTRL_W, 12, width of opaque ALU/branch control bundle passed through to EX
CNT_W, 16, width of load-use bubble counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_pc  in  32  PC of decode instruction
id_rs  in  5  source register A index
id_rt  in  5  source register B index
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_w  in  5  destination register index
id_reg_we  in  1  instruction writes register file
id_mem_read  in  1  instruction is a load
id_a_data  in  32  operand A from register file
id_b_data  in  32  operand B from register file
id_imm  in  32  extended immediate
id_ctrl  in  CTRL_W  control bundle
ex_flush  in  1  taken branch/jump resolved in EX; kill decode instruction
mem_hold  in  1  memory stall; freeze this register
ex_valid, ex_reg_we, ex_mem_read  out  1 each  registered copies
ex_pc, ex_a_data, ex_b_data, ex_imm  out  32 each  registered copies
ex_rs, ex_rt, ex_w  out  5 each  registered copies
ex_ctrl  out  CTRL_W  registered copy
load_use_stall  out  1  combinational; tells PC/IF-ID to hold this cycle
bubble_cnt  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset: every registered output and bubble_cnt = 0 on the rising edge with rst=1; rst overrides all other inputs.
- Hazard (combinational): hazard = ex_valid & ex_mem_read & (ex_w != 0) & id_valid & ((id_uses_rs & id_rs == ex_w) | (id_uses_rt & id_rt == ex_w)).
- load_use_stall = hazard & ~ex_flush & ~mem_hold. Under mem_hold the whole pipe freezes already, so no separate stall is raised.
- Per-edge update, priority high to low:
  1. rst: clear all.
  2. ex_flush: load bubble. All ex_* outputs = 0, including data fields.
  3. mem_hold: all ex_* outputs retain their value.
  4. hazard: load bubble as in 2; bubble_cnt += 1, saturating at all-ones.
  5. otherwise: load all id_* fields. ex_valid = id_valid. ex_reg_we and ex_mem_read are gated by id_valid.
- Latency: exactly one cycle from id_* to ex_*.
- Stall behaviour: while load_use_stall = 1, upstream re-presents the same decode instruction. The next cycle the load has left EX, hazard drops, and the instruction enters.
- A load writing r0 never stalls. Two back-to-back loads with the second dependent on the first stall exactly one cycle.
- bubble_cnt increments only on a case-4 edge. It never increments on flush or hold, and holds at 2^CNT_W-1 once saturated.
- Operand forwarding is not done here. The register file's write-through and the EX forwarding unit cover the remaining RAW cases.

Decomposition:
- Shared package: REG_ZERO (5'd0), CTRL_W default, and the control-bundle field offsets used by EX.
- One natural sub-module: load_use_detect. It is purely combinational, takes the ex_* load info and the id_* source indices, and outputs hazard. The remaining logic stays flat.

Test Plan:
- Reset: drive rst=1 for 2 cycles with arbitrary id_* inputs -> all ex_* = 0, bubble_cnt = 0, load_use_stall = 0.
- Pass-through: id_valid=1, pc=0x100, a=0xDEADBEEF, b=5, w=3, reg_we=1 -> next cycle ex_pc=0x100, ex_a_data=0xDEADBEEF, ex_w=3, ex_reg_we=1.
- Load-use: EX holds a load with w=8. ID has rs=8, uses_rs=1 -> load_use_stall=1 that cycle; next cycle ex_valid=0 and bubble_cnt=1; the following cycle the ID instruction enters and stall=0. Same setup with w=0 -> no stall.
- Flush vs hazard: hazard conditions true and ex_flush=1 -> load_use_stall=0, next ex_valid=0, bubble_cnt unchanged.
- Hold: mem_hold=1 for 3 cycles while ID changes -> ex_* constant, no stall, no count. Release -> new ID contents load.
- Saturation: with CNT_W=2, force 5 load-use bubbles -> bubble_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Purpose: shared types and constants for the ID/EX pipeline register slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   REG_ZERO       - architectural zero register index (writes are discarded)
//   CTRL_W_DEF     - default width of the opaque ALU/branch control bundle
//   CNT_W_DEF      - default width of the load-use bubble counter
//   CTRL_*         - field offsets inside the control bundle, decoded by EX
//   ex_fields_t    - registered EX-side fields other than the control bundle
package id_ex_stage_reg_pkg;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         CTRL_W_DEF = 12;
  localparam int         CNT_W_DEF  = 16;

  // Control bundle layout. This stage never looks inside the bundle; the
  // offsets live here so decode (producer) and EX (consumer) agree on them.
  localparam int CTRL_ALU_OP_LSB   = 0;
  localparam int CTRL_ALU_OP_W     = 4;
  localparam int CTRL_ALU_SRC_IMM  = 4;
  localparam int CTRL_BRANCH       = 5;
  localparam int CTRL_BR_COND_LSB  = 6;
  localparam int CTRL_BR_COND_W    = 3;
  localparam int CTRL_JUMP         = 9;
  localparam int CTRL_JUMP_REG     = 10;
  localparam int CTRL_LINK         = 11;

  // Everything the stage registers except the parameterised control bundle.
  typedef struct packed {
    logic        valid;
    logic        reg_we;
    logic        mem_read;
    logic [31:0] pc;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  w;
  } ex_fields_t;

  // A bubble is an all-zero slot: invalid, no side effects, data cleared so
  // nothing stale is visible to EX or to debug tooling.
  localparam ex_fields_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Purpose: decode-side and execute-side signal bundle of the ID/EX register.
// Latency: n/a (wiring only).
// Backpressure: none carried here; stall/hold travel as plain scalar ports.
//
// Modports:
//   master - decode/pipeline side: drives id_*, observes ex_*
//   slave  - the stage register: consumes id_*, drives ex_*
interface id_ex_stage_reg_if #(
  parameter int CTRL_W = id_ex_stage_reg_pkg::CTRL_W_DEF
);

  // Decode side
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [4:0]        id_w;
  logic              id_reg_we;
  logic              id_mem_read;
  logic [31:0]       id_a_data;
  logic [31:0]       id_b_data;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;

  // Execute side (registered copies)
  logic              ex_valid;
  logic              ex_reg_we;
  logic              ex_mem_read;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_a_data;
  logic [31:0]       ex_b_data;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_w;
  logic [CTRL_W-1:0] ex_ctrl;

  modport master (
    output id_valid, id_pc, id_rs, id_rt, id_uses_rs, id_uses_rt, id_w,
           id_reg_we, id_mem_read, id_a_data, id_b_data, id_imm, id_ctrl,
    input  ex_valid, ex_reg_we, ex_mem_read, ex_pc, ex_a_data, ex_b_data,
           ex_imm, ex_rs, ex_rt, ex_w, ex_ctrl
  );

  modport slave (
    input  id_valid, id_pc, id_rs, id_rt, id_uses_rs, id_uses_rt, id_w,
           id_reg_we, id_mem_read, id_a_data, id_b_data, id_imm, id_ctrl,
    output ex_valid, ex_reg_we, ex_mem_read, ex_pc, ex_a_data, ex_b_data,
           ex_imm, ex_rs, ex_rt, ex_w, ex_ctrl
  );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Purpose: flags a decode instruction that reads the destination of a load now in EX.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller turns hazard into a stall/bubble.
//
// Ports:
//   ex_valid, ex_mem_read, ex_w      - instruction currently in EX
//   id_valid, id_rs, id_rt,
//   id_uses_rs, id_uses_rt           - instruction currently in decode
//   hazard                           - load-use dependency present
module id_ex_stage_reg_load_use_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_w,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       hazard
);

  logic ex_is_load;
  logic rs_dep;
  logic rt_dep;

  // A load targeting r0 produces nothing readable, so it can never cause a
  // dependency even if decode names r0 as a source.
  assign ex_is_load = ex_valid & ex_mem_read & (ex_w != REG_ZERO);
  assign rs_dep     = id_uses_rs & (id_rs == ex_w);
  assign rt_dep     = id_uses_rt & (id_rt == ex_w);
  assign hazard     = ex_is_load & id_valid & (rs_dep | rt_dep);

endmodule

// File: rtl/id_ex_stage_reg.sv
// Purpose: ID/EX pipeline register with load-use bubble insertion and a bubble counter.
// Latency: one cycle id_* -> ex_*; load_use_stall is combinational in the same cycle.
// Backpressure: mem_hold freezes the register; load_use_stall asks PC/IF-ID to re-present decode.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset (overrides everything)
//   pipe (slave)    - id_* decode fields in, ex_* registered copies out
//   ex_flush        - taken branch/jump in EX; the decode instruction is killed
//   mem_hold        - memory stall; every ex_* output keeps its value
//   load_use_stall  - decode must hold this cycle (bubble goes to EX)
//   bubble_cnt      - saturating count of load-use bubbles inserted
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_reg_if.slave  pipe,
  input  logic              ex_flush,
  input  logic              mem_hold,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ex_fields_t        ex_q;
  ex_fields_t        ex_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              hazard;

  // Hazard is evaluated against the registered EX slot, not the incoming one.
  id_ex_stage_reg_load_use_detect u_load_use_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_w        (ex_q.w),
    .id_valid    (pipe.id_valid),
    .id_rs       (pipe.id_rs),
    .id_rt       (pipe.id_rt),
    .id_uses_rs  (pipe.id_uses_rs),
    .id_uses_rt  (pipe.id_uses_rt),
    .hazard      (hazard)
  );

  // A flush already discards the decode instruction, and a hold already
  // freezes the whole pipe, so neither needs an extra stall request.
  assign load_use_stall = hazard & ~ex_flush & ~mem_hold;

  always_comb begin
    ex_d   = ex_q;
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    if (ex_flush) begin
      ex_d   = EX_BUBBLE;
      ctrl_d = '0;
    end else if (mem_hold) begin
      // keep everything, including the counter
    end else if (hazard) begin
      ex_d   = EX_BUBBLE;
      ctrl_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d.valid    = pipe.id_valid;
      // Side-effect controls are gated so an empty decode slot can never
      // write the register file or issue a load.
      ex_d.reg_we   = pipe.id_valid & pipe.id_reg_we;
      ex_d.mem_read = pipe.id_valid & pipe.id_mem_read;
      ex_d.pc       = pipe.id_pc;
      ex_d.a_data   = pipe.id_a_data;
      ex_d.b_data   = pipe.id_b_data;
      ex_d.imm      = pipe.id_imm;
      ex_d.rs       = pipe.id_rs;
      ex_d.rt       = pipe.id_rt;
      ex_d.w        = pipe.id_w;
      ctrl_d        = pipe.id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= EX_BUBBLE;
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pipe.ex_valid    = ex_q.valid;
  assign pipe.ex_reg_we   = ex_q.reg_we;
  assign pipe.ex_mem_read = ex_q.mem_read;
  assign pipe.ex_pc       = ex_q.pc;
  assign pipe.ex_a_data   = ex_q.a_data;
  assign pipe.ex_b_data   = ex_q.b_data;
  assign pipe.ex_imm      = ex_q.imm;
  assign pipe.ex_rs       = ex_q.rs;
  assign pipe.ex_rt       = ex_q.rt;
  assign pipe.ex_w        = ex_q.w;
  assign pipe.ex_ctrl     = ctrl_q;
  assign bubble_cnt       = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Purpose: self-checking bench for id_ex_stage_reg (scoreboard of expected EX slots).
// Latency: expects ex_* one cycle after id_*; stall checked in the same cycle.
// Backpressure: exercises ex_flush, mem_hold and load-use stalls.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam int CTRL_W = 12;
  localparam int CNT_W  = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    ex_fields_t        ex;
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             ex_flush;
  logic             mem_hold;
  logic             load_use_stall;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage_reg_if #(.CTRL_W(CTRL_W)) bus ();

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe           (bus.slave),
    .ex_flush       (ex_flush),
    .mem_hold       (mem_hold),
    .load_use_stall (load_use_stall),
    .bubble_cnt     (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Bench-side reference state
  ex_fields_t        m_ex;
  logic [CTRL_W-1:0] m_ctrl;
  logic [CNT_W-1:0]  m_cnt;
  exp_t              sb[$];
  logic              last_stall;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt,
                           input logic [4:0] w, input logic we, input logic mr);
    bus.id_valid    = v;
    bus.id_pc       = pc;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.id_w        = w;
    bus.id_reg_we   = we;
    bus.id_mem_read = mr;
    bus.id_a_data   = $urandom;
    bus.id_b_data   = $urandom;
    bus.id_imm      = $urandom;
    bus.id_ctrl     = CTRL_W'($urandom);
  endtask

  // One clock: drive controls, check the combinational stall, push the
  // expected EX slot, then pop and compare it after the edge.
  task automatic tick(input logic flush, input logic hold, input logic r, input bit chk_stall);
    logic       hz;
    logic       es;
    exp_t       e;
    exp_t       got;
    ex_fields_t obs;
    @(negedge clk);
    ex_flush = flush;
    mem_hold = hold;
    rst      = r;
    #1;
    hz = m_ex.valid & m_ex.mem_read & (m_ex.w != 5'd0) & bus.id_valid &
         ((bus.id_uses_rs & (bus.id_rs == m_ex.w)) | (bus.id_uses_rt & (bus.id_rt == m_ex.w)));
    es = hz & ~flush & ~hold;
    last_stall = load_use_stall;
    if (chk_stall) begin
      tests++;
      assert (load_use_stall === es) else begin
        fails++;
        $error("FAIL stall observed=%b expected=%b", load_use_stall, es);
      end
    end
    if (r) begin
      m_ex = '0; m_ctrl = '0; m_cnt = '0;
    end else if (flush) begin
      m_ex = '0; m_ctrl = '0;
    end else if (hold) begin
      // unchanged
    end else if (hz) begin
      m_ex = '0; m_ctrl = '0;
      if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
    end else begin
      m_ex.valid    = bus.id_valid;
      m_ex.reg_we   = bus.id_valid & bus.id_reg_we;
      m_ex.mem_read = bus.id_valid & bus.id_mem_read;
      m_ex.pc       = bus.id_pc;
      m_ex.a_data   = bus.id_a_data;
      m_ex.b_data   = bus.id_b_data;
      m_ex.imm      = bus.id_imm;
      m_ex.rs       = bus.id_rs;
      m_ex.rt       = bus.id_rt;
      m_ex.w        = bus.id_w;
      m_ctrl        = bus.id_ctrl;
    end
    e.ex = m_ex; e.ctrl = m_ctrl; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs.valid    = bus.ex_valid;
    obs.reg_we   = bus.ex_reg_we;
    obs.mem_read = bus.ex_mem_read;
    obs.pc       = bus.ex_pc;
    obs.a_data   = bus.ex_a_data;
    obs.b_data   = bus.ex_b_data;
    obs.imm      = bus.ex_imm;
    obs.rs       = bus.ex_rs;
    obs.rt       = bus.ex_rt;
    obs.w        = bus.ex_w;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      tests++;
      assert (obs === got.ex) else begin
        fails++;
        $error("FAIL ex_fields observed=%h expected=%h", obs, got.ex);
      end
      tests++;
      assert (bus.ex_ctrl === got.ctrl) else begin
        fails++;
        $error("FAIL ex_ctrl observed=%h expected=%h", bus.ex_ctrl, got.ctrl);
      end
      tests++;
      assert (bubble_cnt === got.cnt) else begin
        fails++;
        $error("FAIL bubble_cnt observed=%0d expected=%0d", bubble_cnt, got.cnt);
      end
    end
  endtask

  initial begin
    logic [CNT_W-1:0] sat_seq [5];
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    m_ex = '0; m_ctrl = '0; m_cnt = '0; last_stall = 1'b0;
    rst = 1'b1; ex_flush = 1'b0; mem_hold = 1'b0;

    // Reset with junk decode inputs, including a load that would hazard
    set_instr(1'b1, 32'h0000_0BAD, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset_ex_pc", bus.ex_pc, 32'd0);
    chk("reset_cnt", 32'(bubble_cnt), 32'd0);
    chk("reset_stall", 32'(last_stall), 32'd0);

    // Pass-through
    set_instr(1'b1, 32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    bus.id_a_data = 32'hDEAD_BEEF;
    bus.id_b_data = 32'd5;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pass_pc", bus.ex_pc, 32'h100);
    chk("pass_a", bus.ex_a_data, 32'hDEAD_BEEF);
    chk("pass_b", bus.ex_b_data, 32'd5);
    chk("pass_w", 32'(bus.ex_w), 32'd3);
    chk("pass_we", 32'(bus.ex_reg_we), 32'd1);

    // Load w=8, then dependent on rs: one bubble, then entry
    set_instr(1'b1, 32'h104, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    set_instr(1'b1, 32'h108, 5'd8, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu_cnt", 32'(bubble_cnt), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lu_enter_stall", 32'(last_stall), 32'd0);
    chk("lu_enter_pc", bus.ex_pc, 32'h108);

    // Load to r0 never stalls
    set_instr(1'b1, 32'h10C, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    set_instr(1'b1, 32'h110, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("r0_no_stall", 32'(last_stall), 32'd0);

    // Back-to-back loads, second depends on first via rt: exactly one bubble
    set_instr(1'b1, 32'h114, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    set_instr(1'b1, 32'h118, 5'd3, 5'd12, 1'b0, 1'b1, 5'd13, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_stall", 32'(last_stall), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_once", 32'(last_stall), 32'd0);
    // Index match but source not used, and an invalid dependent slot
    set_instr(1'b1, 32'h11C, 5'd13, 5'd13, 1'b0, 1'b0, 5'd14, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    set_instr(1'b1, 32'h120, 5'd1, 5'd2, 1'b0, 1'b0, 5'd15, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    set_instr(1'b0, 32'h124, 5'd15, 5'd15, 1'b1, 1'b1, 5'd16, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("invalid_gate_we", 32'(bus.ex_reg_we), 32'd0);

    // Flush beats hazard
    set_instr(1'b1, 32'h128, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    set_instr(1'b1, 32'h12C, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_stall", 32'(last_stall), 32'd0);
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_cnt", 32'(bubble_cnt), 32'd2);

    // Hold three cycles with a dependent, changing decode slot
    set_instr(1'b1, 32'h130, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, 32'h200 + 32'(i * 4), 5'd6, 5'(i), 1'b1, 1'b1, 5'd20, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      chk("hold_pc", bus.ex_pc, 32'h130);
      chk("hold_stall", 32'(last_stall), 32'd0);
    end
    chk("hold_cnt", 32'(bubble_cnt), 32'd2);
    set_instr(1'b1, 32'h300, 5'd1, 5'd2, 1'b1, 1'b1, 5'd21, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("release_pc", bus.ex_pc, 32'h300);

    // Saturation after a fresh reset
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      set_instr(1'b1, 32'h400 + 32'(i * 8), 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      set_instr(1'b1, 32'h404 + 32'(i * 8), 5'd7, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      chk("sat_cnt", 32'(bubble_cnt), 32'(sat_seq[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
